imem_loader: RTL and testbench

- Boot-time program loader; the write side of the 1024x32 instruction memory.
- Receives a framed byte stream over a valid/ready handshake, e.g. from a UART receiver.
- Assembles big-endian 32-bit words and writes them to consecutive instruction-memory addresses starting at 0.
- Holds the CPU in reset/stall until a frame completes with a good checksum.

---
 rtl/imem_loader_pkg.sv | 24 ++
 rtl/imem_word_assembler.sv | 62 ++++++
 rtl/imem_loader.sv | 143 ++++++++++++++
 tb/tb_imem_loader.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader and the
// instruction memory itself: memory geometry, the default frame-start marker,
// loader state encoding and a frame-length legality helper.
package imem_loader_pkg;

  localparam int         IMEM_WORDS     = 1024;
  localparam int         IMEM_ADDR_W    = 10;
  localparam logic [7:0] START_BYTE_DEF = 8'hA5;

  // Loader FSM encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LEN_HI = 3'd1;
  localparam logic [2:0] ST_LEN_LO = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_CHECK  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;
  localparam logic [2:0] ST_ERROR  = 3'd6;

  // A frame may carry 1 .. 2**aw words; anything else is rejected.
  function automatic logic len_ok(input logic [15:0] n, input int aw);
    return (n != 16'd0) && ({1'b0, n} <= (17'd1 << aw));
  endfunction

endpackage

// File: rtl/imem_word_assembler.sv
// Big-endian word assembler for the loader payload.
//   clk         system clock
//   reset       synchronous active-high reset
//   clr_i       start of a new payload: clears byte counter and checksum
//   byte_vld_i  an accepted payload byte is on byte_i this cycle
//   byte_i      payload byte
//   word_rdy_o  this byte completes a word (combinational pulse)
//   word_o      assembled word including the current byte (valid with word_rdy_o)
//   chk_o       XOR of all payload bytes accepted since clr_i
module imem_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_i,
  input  logic        byte_vld_i,
  input  logic [7:0]  byte_i,
  output logic        word_rdy_o,
  output logic [31:0] word_o,
  output logic [7:0]  chk_o
);

  logic [1:0]  cnt_q,   cnt_d;
  logic [23:0] shift_q, shift_d;
  logic [7:0]  chk_q,   chk_d;

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    chk_d   = chk_q;
    if (clr_i) begin
      cnt_d = 2'd0;
      chk_d = 8'd0;
    end else if (byte_vld_i) begin
      cnt_d   = cnt_q + 2'd1;
      shift_d = {shift_q[15:0], byte_i};
      chk_d   = chk_q ^ byte_i;
    end
  end

  // The fourth byte is not stored; it is merged straight into the output word
  // so the write can be registered on the same edge that accepts it.
  assign word_rdy_o = byte_vld_i && (cnt_q == 2'd3);
  assign word_o     = {shift_q, byte_i};
  assign chk_o      = chk_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 2'd0;
      chk_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
      chk_q <= chk_d;
    end
  end

  // Partial-word bytes carry no control meaning, so they are not reset.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time program loader: parses a framed byte stream
//   START_BYTE, LEN_HI, LEN_LO, N x 4 payload bytes (MSB first), CHK
// and writes the words to instruction memory from address 0. The CPU is held
// until a frame ends with a matching XOR checksum.
//   clk      system clock, rising edge
//   reset    synchronous active-high reset
//   RxData   incoming byte
//   RxValid  RxData valid this cycle
//   RxReady  byte accepted when RxValid && RxReady (low only during reset)
//   WrEn     one-cycle instruction-memory write strobe
//   WrAddr   word address of the write (held between writes)
//   WrData   word of the write (held between writes)
//   CpuHold  keep the CPU stalled; low only after a good frame
//   Done     good frame loaded (sticky until the next START_BYTE)
//   Error    frame rejected (sticky until the next START_BYTE)
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         ADDR_W     = IMEM_ADDR_W,
  parameter logic [7:0] START_BYTE = START_BYTE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        RxData,
  input  logic              RxValid,
  output logic              RxReady,
  output logic              WrEn,
  output logic [ADDR_W-1:0] WrAddr,
  output logic [31:0]       WrData,
  output logic              CpuHold,
  output logic              Done,
  output logic              Error
);

  logic [2:0]        state_q,   state_d;
  logic [7:0]        len_hi_q,  len_hi_d;
  logic [15:0]       len_q,     len_d;
  // One bit wider than the address so a full 2**ADDR_W frame never wraps.
  logic [ADDR_W:0]   widx_q,    widx_d;
  logic              wr_en_q,   wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;

  logic        accept;
  logic        asm_clr;
  logic        asm_vld;
  logic        word_rdy;
  logic [31:0] word;
  logic [7:0]  chk;
  logic        last_word;

  // Every write completes in one cycle, so the stream is never throttled.
  assign RxReady = ~reset;
  assign accept  = RxValid && RxReady;
  assign asm_clr = accept && (state_q == ST_LEN_LO);
  assign asm_vld = accept && (state_q == ST_DATA);

  imem_word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (asm_clr),
    .byte_vld_i (asm_vld),
    .byte_i     (RxData),
    .word_rdy_o (word_rdy),
    .word_o     (word),
    .chk_o      (chk)
  );

  assign last_word = (17'(widx_q) + 17'd1) == {1'b0, len_q};

  always_comb begin
    state_d   = state_q;
    len_hi_d  = len_hi_q;
    len_d     = len_q;
    widx_d    = widx_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && (RxData == START_BYTE)) state_d = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (accept) begin
          len_hi_d = RxData;
          state_d  = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (accept) begin
          len_d   = {len_hi_q, RxData};
          widx_d  = '0;
          state_d = len_ok({len_hi_q, RxData}, ADDR_W) ? ST_DATA : ST_ERROR;
        end
      end
      ST_DATA: begin
        if (word_rdy) begin
          wr_en_d   = 1'b1;
          wr_addr_d = widx_q[ADDR_W-1:0];
          wr_data_d = word;
          widx_d    = widx_q + 1'b1;
          if (last_word) state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (accept) state_d = (RxData == chk) ? ST_DONE : ST_ERROR;
      end
      ST_DONE, ST_ERROR: begin
        if (accept && (RxData == START_BYTE)) state_d = ST_LEN_HI;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and write-port registers; WrEn follows the 4th byte by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      len_hi_q  <= 8'd0;
      len_q     <= 16'd0;
      widx_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      len_hi_q  <= len_hi_d;
      len_q     <= len_d;
      widx_q    <= widx_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign WrEn    = wr_en_q;
  assign WrAddr  = wr_addr_q;
  assign WrData  = wr_data_q;
  assign Done    = (state_q == ST_DONE);
  assign Error   = (state_q == ST_ERROR);
  assign CpuHold = (state_q != ST_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a frame-level model parses each byte stream
// into expected writes and per-byte status; a negedge process compares the DUT
// against it every cycle, and literal checks pin the model after each scenario.
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  RxData;
  logic        RxValid;
  logic        RxReady;
  logic        WrEn;
  logic [9:0]  WrAddr;
  logic [31:0] WrData;
  logic        CpuHold;
  logic        Done;
  logic        Error;

  imem_loader dut (
    .clk     (clk),
    .reset   (reset),
    .RxData  (RxData),
    .RxValid (RxValid),
    .RxReady (RxReady),
    .WrEn    (WrEn),
    .WrAddr  (WrAddr),
    .WrData  (WrData),
    .CpuHold (CpuHold),
    .Done    (Done),
    .Error   (Error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0]  strm[$];       // byte stream of the current scenario
  int          exp_st[$];     // status after each byte: 0 busy/idle, 1 done, 2 error
  logic [41:0] wr_at[int];    // keyed by stream index of a word's 4th byte
  logic [41:0] we_due[int];   // keyed by negedge number where WrEn must be seen
  logic [41:0] wlog[$];       // writes observed on the DUT
  int          exp_stat = 0;
  int          ncyc = 0;
  bit          chk_en = 0;
  bit          rst_prev = 0;
  logic [9:0]  last_a = '0;
  logic [31:0] last_d = '0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Frame-level reading of the stream.
  task automatic model_build();
    int i, n, st, nw, got;
    logic [7:0]  c;
    logic [31:0] w;
    n = strm.size();
    exp_st.delete();
    wr_at.delete();
    for (int k = 0; k < n; k++) exp_st.push_back(0);
    st = 0;
    i  = 0;
    while (i < n) begin
      if (strm[i] != 8'hA5) begin
        exp_st[i] = st;
        i++;
        continue;
      end
      st = 0;
      i++;
      if (i + 1 >= n) break;
      nw = int'({strm[i], strm[i+1]});
      if (nw == 0 || nw > 1024) st = 2;
      exp_st[i+1] = st;
      i += 2;
      if (st == 2) continue;
      c   = 8'h00;
      got = 0;
      while (got < nw && i + 3 < n) begin
        w = {strm[i], strm[i+1], strm[i+2], strm[i+3]};
        c = c ^ strm[i] ^ strm[i+1] ^ strm[i+2] ^ strm[i+3];
        wr_at[i+3] = {10'(got), w};
        got++;
        i += 4;
      end
      if (got < nw || i >= n) break;
      st = (strm[i] == c) ? 1 : 2;
      exp_st[i] = st;
      i++;
    end
  endtask

  // All driver tasks start and end 2 time units after a rising edge.
  task automatic send(input int idx, input int gap);
    int tgt;
    RxData  = strm[idx];
    RxValid = 1'b1;
    tgt     = ncyc + 2;
    @(posedge clk); #2;
    if (wr_at.exists(idx)) we_due[tgt] = wr_at[idx];
    exp_stat = exp_st[idx];
    RxValid  = 1'b0;
    for (int g = 0; g < gap; g++) begin
      RxData = 8'hA5;
      @(posedge clk); #2;
    end
  endtask

  task automatic run_stream(input int gap);
    model_build();
    for (int i = 0; i < strm.size(); i++) send(i, gap);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic do_reset(input logic rv, input logic [7:0] rb);
    RxValid = rv;
    RxData  = rb;
    reset   = 1'b1;
    @(posedge clk); #2;
    reset    = 1'b0;
    RxValid  = 1'b0;
    we_due.delete();
    exp_stat = 0;
    wlog.delete();
    strm.delete();
  endtask

  task automatic push_s1(input logic [7:0] chkb);
    strm.push_back(8'hA5); strm.push_back(8'h00); strm.push_back(8'h02);
    strm.push_back(8'h00); strm.push_back(8'h00); strm.push_back(8'h00); strm.push_back(8'h01);
    strm.push_back(8'h8C); strm.push_back(8'h02); strm.push_back(8'h00); strm.push_back(8'h04);
    strm.push_back(chkb);
  endtask

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      ncyc++;
      if (rst_prev) begin
        last_a = '0;
        last_d = '0;
      end
      if (chk_en) begin
        check("rxready", 64'(RxReady), 64'(!reset));
        if (we_due.exists(ncyc)) begin
          check("wren", 64'(WrEn), 64'd1);
          check("wraddr", 64'(WrAddr), 64'(we_due[ncyc][41:32]));
          check("wrdata", 64'(WrData), 64'(we_due[ncyc][31:0]));
          last_a = we_due[ncyc][41:32];
          last_d = we_due[ncyc][31:0];
        end else begin
          check("wren_low", 64'(WrEn), 64'd0);
          check("wraddr_hold", 64'(WrAddr), 64'(last_a));
          check("wrdata_hold", 64'(WrData), 64'(last_d));
        end
        if (WrEn === 1'b1) wlog.push_back({WrAddr, WrData});
        check("done", 64'(Done), 64'(exp_stat == 1));
        check("error", 64'(Error), 64'(exp_stat == 2));
        check("cpuhold", 64'(CpuHold), 64'(exp_stat != 1));
      end
      rst_prev = reset;
    end
  end

  initial begin
    reset   = 1'b1;
    RxValid = 1'b0;
    RxData  = 8'h00;
    @(posedge clk); #2;
    chk_en = 1;
    do_reset(1'b1, 8'hA5);
    idle(1);
    check("rst_wraddr", 64'(WrAddr), 64'd0);
    check("rst_wrdata", 64'(WrData), 64'd0);

    // 1: basic two-word frame
    push_s1(8'h8B);
    run_stream(0);
    check("s1_model_n", 64'(wr_at.num()), 64'd2);
    check("s1_model_w1", 64'(wr_at[10]), {22'd0, 10'd1, 32'h8C020004});
    idle(2);
    check("s1_nwr", 64'(wlog.size()), 64'd2);
    check("s1_w0", 64'(wlog[0]), {22'd0, 10'd0, 32'h00000001});
    check("s1_w1", 64'(wlog[1]), {22'd0, 10'd1, 32'h8C020004});
    check("s1_done", 64'({Done, CpuHold, Error}), 64'b100);

    // 2: bad checksum, then a good one-word frame
    do_reset(1'b0, 8'h00);
    push_s1(8'h8C);
    strm.push_back(8'hA5); strm.push_back(8'h00); strm.push_back(8'h01);
    strm.push_back(8'h12); strm.push_back(8'h34); strm.push_back(8'h56); strm.push_back(8'h78);
    strm.push_back(8'h08);
    model_build();
    check("s2_model_err", 64'(exp_st[11]), 64'd2);
    for (int i = 0; i < 12; i++) send(i, 0);
    idle(1);
    check("s2_err", 64'({Done, CpuHold, Error}), 64'b011);
    for (int i = 12; i < strm.size(); i++) send(i, 0);
    idle(2);
    check("s2_nwr", 64'(wlog.size()), 64'd3);
    check("s2_w", 64'(wlog[2]), {22'd0, 10'd0, 32'h12345678});
    check("s2_done", 64'({Done, CpuHold, Error}), 64'b100);

    // 3a/3b: illegal lengths
    do_reset(1'b0, 8'h00);
    strm.push_back(8'hA5); strm.push_back(8'h00); strm.push_back(8'h00);
    run_stream(0);
    idle(2);
    check("s3a_err", 64'({Done, CpuHold, Error}), 64'b011);
    check("s3a_nwr", 64'(wlog.size()), 64'd0);
    do_reset(1'b0, 8'h00);
    strm.push_back(8'hA5); strm.push_back(8'h04); strm.push_back(8'h01);
    run_stream(0);
    idle(2);
    check("s3b_err", 64'({Done, CpuHold, Error}), 64'b011);
    check("s3b_nwr", 64'(wlog.size()), 64'd0);

    // 3c: full-capacity frame
    do_reset(1'b0, 8'h00);
    strm.push_back(8'hA5); strm.push_back(8'h04); strm.push_back(8'h00);
    for (int k = 0; k < 4097; k++) strm.push_back(8'h00);
    run_stream(0);
    idle(2);
    check("s3c_nwr", 64'(wlog.size()), 64'd1024);
    check("s3c_last", 64'(wlog[1023]), {22'd0, 10'd1023, 32'h0});
    check("s3c_done", 64'({Done, CpuHold, Error}), 64'b100);

    // 4: idle garbage and gaps between bytes
    do_reset(1'b0, 8'h00);
    strm.push_back(8'h00); strm.push_back(8'hFF); strm.push_back(8'h13);
    push_s1(8'h8B);
    run_stream(1);
    idle(2);
    check("s4_nwr", 64'(wlog.size()), 64'd2);
    check("s4_w1", 64'(wlog[1]), {22'd0, 10'd1, 32'h8C020004});
    check("s4_done", 64'({Done, CpuHold, Error}), 64'b100);

    // 5: reset one cycle after the 3rd byte of word 1
    do_reset(1'b0, 8'h00);
    push_s1(8'h8B);
    void'(strm.pop_back()); void'(strm.pop_back());
    run_stream(0);
    check("s5_pre_nwr", 64'(wlog.size()), 64'd1);
    do_reset(1'b1, 8'h04);
    idle(3);
    check("s5_nwr", 64'(wlog.size()), 64'd0);
    check("s5_out", 64'({Done, CpuHold, Error, WrEn}), 64'b0100);
    check("s5_addr", 64'(WrAddr), 64'd0);
    check("s5_data", 64'(WrData), 64'd0);

    // 6: START_BYTE values inside the payload
    do_reset(1'b0, 8'h00);
    strm.push_back(8'hA5); strm.push_back(8'h00); strm.push_back(8'h01);
    for (int k = 0; k < 4; k++) strm.push_back(8'hA5);
    strm.push_back(8'h00);
    run_stream(0);
    idle(2);
    check("s6_nwr", 64'(wlog.size()), 64'd1);
    check("s6_w", 64'(wlog[0]), {22'd0, 10'd0, 32'hA5A5A5A5});
    check("s6_done", 64'({Done, CpuHold, Error}), 64'b100);

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
